// File: rtl/arm_mem_pkg.sv
// arm_mem_pkg: shared address/data widths and write-buffer drain states
package arm_mem_pkg;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  typedef enum logic {IDLE, BUSY} drain_state_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: circular store FIFO with youngest-match read forwarding over valid entries
module wb_fifo
  import arm_mem_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW = ADDR_W,
  parameter int DW = DATA_W,
  localparam int PW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          upd,
  input  logic          pop,
  input  logic [PW:0]   count,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [AW-1:0] head_addr,
  output logic [DW-1:0] head_data,
  output logic [AW-1:0] young_addr,
  output logic          rd_hit,
  output logic [DW-1:0] rd_data
);
  logic [AW-1:0] addr_q [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [PW-1:0] head, tail, young, idx;
  assign young = tail - PW'(1);
  assign head_addr = addr_q[head];
  assign head_data = data_q[head];
  assign young_addr = addr_q[young];
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop) head <= head + PW'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail] <= wr_addr;
      data_q[tail] <= wr_data;
    end
    if (upd) data_q[young] <= wr_data;
  end
  // Walk oldest to youngest so the last match (youngest) wins.
  always_comb begin
    rd_hit = 1'b0;
    rd_data = '0;
    idx = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if (i < int'(count) && addr_q[idx] == rd_addr) begin
        rd_hit = 1'b1;
        rd_data = data_q[idx];
      end
    end
  end
endmodule

// File: rtl/sram_write_buffer.sv
// sram_write_buffer: cache store buffer draining to SRAM, with youngest-match read forwarding.
// Define WB_COALESCE_EN to merge a store into the youngest pending entry with the same address.
module sram_write_buffer
  import arm_mem_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW = ADDR_W,
  parameter int DW = DATA_W
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ready,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_hit,
  output logic [DW-1:0] rd_data,
  output logic          sram_req,
  output logic [AW-1:0] sram_addr,
  output logic [DW-1:0] sram_wdata,
  input  logic          sram_ack,
  output logic          empty
);
  localparam int CW = $clog2(DEPTH) + 1;
`ifdef WB_COALESCE_EN
  localparam bit COALESCE = 1'b1;
`else
  localparam bit COALESCE = 1'b0;
`endif
  drain_state_t state, state_nx;
  logic [CW-1:0] count, count_nx;
  logic [AW-1:0] young_addr;
  logic coal, accept, alloc, upd, pop;
  // The head in flight must stay stable, so never merge into it while BUSY.
  assign coal = COALESCE && count != '0 && wr_addr == young_addr && !(state == BUSY && count == CW'(1));
  assign wr_ready = count < CW'(DEPTH) || coal;
  assign accept = wr_req && wr_ready;
  assign alloc = accept && !coal;
  assign upd = accept && coal;
  assign pop = sram_ack && state == BUSY;
  assign count_nx = count + CW'(alloc) - CW'(pop);
  assign sram_req = state == BUSY;
  assign empty = count == '0;
  always_comb begin
    state_nx = state == IDLE ? (count != '0 ? BUSY : IDLE) : (pop && count_nx == '0 ? IDLE : BUSY);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      count <= '0;
    end else begin
      state <= state_nx;
      count <= count_nx;
    end
  end
  wb_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(alloc),
    .upd(upd),
    .pop(pop),
    .count(count),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .rd_addr(rd_addr),
    .head_addr(sram_addr),
    .head_data(sram_wdata),
    .young_addr(young_addr),
    .rd_hit(rd_hit),
    .rd_data(rd_data)
  );
endmodule
